// File: rtl/nibadd_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibadd_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/add4_slice.sv
// Purely combinational 4-bit ripple-carry adder slice.
module add4_slice
    import nibadd_pkg::*;
(
    input  logic [NIB_W-1:0] a4,
    input  logic [NIB_W-1:0] b4,
    input  logic             ci,
    output logic [NIB_W-1:0] s4,
    output logic             co
);

    logic [NIB_W:0] w_c;

    always_comb begin
        w_c    = '0;
        s4     = '0;
        w_c[0] = ci;
        for (int i = 0; i < NIB_W; i++) begin
            s4[i]    = a4[i] ^ b4[i] ^ w_c[i];
            w_c[i+1] = (a4[i] & b4[i]) | (a4[i] & w_c[i]) | (b4[i] & w_c[i]);
        end
        co = w_c[NIB_W];
    end

endmodule

// File: rtl/nibble_add_seq.sv
// WIDTH-bit adder built from one 4-bit slice, one nibble per clock, valid/ready on both sides.
// Define NIBADD_SUB_EN to add the sub port (a - b via inverted b and forced carry-in).
module nibble_add_seq
    import nibadd_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    if ((WIDTH < NIB_W) || ((WIDTH % NIB_W) != 0)) begin : g_bad_width
        $error("nibble_add_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_a, w_a_next;
    logic [WIDTH-1:0] r_b, w_b_next;
    logic             r_sub, w_sub_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic             r_carry, w_carry_next;
    logic [WIDTH-1:0] r_sum, w_sum_next;
    logic             r_cout, w_cout_next;

    logic             w_sub_in;
    logic [NIB_W-1:0] w_a_nibs [NIB];
    logic [NIB_W-1:0] w_b_nibs [NIB];
    logic [NIB_W-1:0] w_a4, w_b4, w_s4;
    logic             w_co;

`ifdef NIBADD_SUB_EN
    assign w_sub_in = sub;
`else
    assign w_sub_in = 1'b0;
`endif

    for (genvar g = 0; g < NIB; g++) begin : g_nibs
        assign w_a_nibs[g] = r_a[g*NIB_W +: NIB_W];
        assign w_b_nibs[g] = r_b[g*NIB_W +: NIB_W];
    end

    // Subtraction is a + ~b + 1; the +1 is seeded into the carry register at accept.
    assign w_a4 = w_a_nibs[r_idx];
    assign w_b4 = w_b_nibs[r_idx] ^ {NIB_W{r_sub}};

    add4_slice u_slice (
        .a4 (w_a4),
        .b4 (w_b4),
        .ci (r_carry),
        .s4 (w_s4),
        .co (w_co)
    );

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_sub_next   = r_sub;
        w_idx_next   = r_idx;
        w_carry_next = r_carry;
        w_sum_next   = r_sum;
        w_cout_next  = r_cout;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_a_next     = a;
                    w_b_next     = b;
                    w_sub_next   = w_sub_in;
                    w_carry_next = w_sub_in ? 1'b1 : cin;
                    w_idx_next   = '0;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (r_idx == IDX_W'(i)) begin
                        w_sum_next[i*NIB_W +: NIB_W] = w_s4;
                    end
                end
                w_carry_next = w_co;
                if (r_idx == LAST_IDX) begin
                    w_idx_next   = '0;
                    w_cout_next  = w_co;
                    w_state_next = DONE;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_sub   <= w_sub_next;
            r_idx   <= w_idx_next;
            r_carry <= w_carry_next;
            r_sum   <= w_sum_next;
            r_cout  <= w_cout_next;
        end
    end

    // Held low while rst is asserted so nothing is offered during the reset cycle.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed self-checking bench for nibble_add_seq at WIDTH=16.
module tb_nibble_add_seq;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    nibble_add_seq #(
        .WIDTH (WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 30) begin
            step();
            n++;
        end
        check_eq({tag, "_in_ready_wait"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Accept one operand set, check latency, optional hold in DONE, check result, drain.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vcin, input logic vsub, input logic [15:0] exp_sum,
                          input logic exp_cout, input int hold);
        int lat = 0;
        wait_in_ready(tag);
        a        = va;
        b        = vb;
        cin      = vcin;
        sub      = vsub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 4);
        check_eq({tag, "_sum"}, {16'd0, sum}, {16'd0, exp_sum});
        check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
        for (int k = 0; k < hold; k++) begin
            step();
            check_eq({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check_eq({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
            check_eq({tag, "_hold_sum"}, {16'd0, sum}, {16'd0, exp_sum});
            check_eq({tag, "_hold_cout"}, {31'd0, cout}, {31'd0, exp_cout});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] bb_a [3];
        logic [15:0] bb_b [3];
        logic [15:0] bb_s [3];
        int          t_prev;
        int          lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        step();
        step();
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_sum", {16'd0, sum}, 32'd0);
        check_eq("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add_1_1", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 0);
        run_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
        run_op("hold_low", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 10);
        run_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 0);
        run_op("mixed", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 0);
        run_op("top_carry", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 0);

        // Reset during the second RUN cycle discards the operation.
        wait_in_ready("abort");
        a        = 16'h1234;
        b        = 16'h1111;
        cin      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_sum", {16'd0, sum}, 32'd0);
        check_eq("abort_cout", {31'd0, cout}, 32'd0);
        check_eq("abort_in_ready_rst", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("abort_no_result", {31'd0, out_valid}, 32'd0);
        end
        run_op("after_abort", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 0);

        // Back-to-back with in_valid and out_ready held high.
        bb_a[0] = 16'h0101; bb_b[0] = 16'h0202; bb_s[0] = 16'h0303;
        bb_a[1] = 16'h00FF; bb_b[1] = 16'h0001; bb_s[1] = 16'h0100;
        bb_a[2] = 16'hABCD; bb_b[2] = 16'h1111; bb_s[2] = 16'hBCDE;
        cin       = 1'b0;
        out_ready = 1'b1;
        a         = bb_a[0];
        b         = bb_b[0];
        in_valid  = 1'b1;
        t_prev    = 0;
        for (int k = 0; k < 3; k++) begin
            wait_in_ready("b2b");
            if (k > 0) check_eq("b2b_spacing", cyc_cnt - t_prev, 6);
            t_prev = cyc_cnt;
            step();
            if (k < 2) begin
                a = bb_a[k+1];
                b = bb_b[k+1];
            end
            lat = 0;
            while (!out_valid && lat < 20) begin
                step();
                lat++;
            end
            check_eq("b2b_latency", lat, 4);
            check_eq("b2b_sum", {16'd0, sum}, {16'd0, bb_s[k]});
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

`ifdef NIBADD_SUB_EN
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0);
        run_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 0);
        run_op("sub_off", 16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
